// File: rtl/axi_defs.sv
// Shared AXI constants and refill FSM encoding for the instruction-cache refill path.
package axi_defs;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         LINE_BEATS = 4;
    localparam int         WORD_W     = 32;
    localparam int         BEAT_W     = 2;
    localparam int         LINE_W     = LINE_BEATS * WORD_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } refill_state_e;
endpackage

// File: rtl/line_assembler.sv
// Collects R-channel beats into a cache line; the beat counter selects the word slot.
module line_assembler
    import axi_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              beat_we_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic [LINE_W-1:0] line_o
);
    logic [BEAT_W-1:0] beat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
        end else if (clear_i) begin
            beat_q <= '0;
        end else if (beat_we_i) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    assign beat_o = beat_q;

    generate
        for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_word
            logic [WORD_W-1:0] word_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_q <= '0;
                end else if (clear_i) begin
                    word_q <= '0;
                end else if (beat_we_i && (beat_q == BEAT_W'(gi))) begin
                    word_q <= rdata_i;
                end
            end

            assign line_o[gi*WORD_W +: WORD_W] = word_q;
        end
    endgenerate
endmodule

// File: rtl/icache_axi_refill.sv
// Turns one cache line-refill request into a 4x32 INCR AXI read burst and returns the line.
module icache_axi_refill
    import axi_defs::*;
#(
    parameter int ID_WIDTH = 4,
    parameter int AXI_ID   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req,
    input  logic [31:0]         rd_addr,
    output logic                ret_valid,
    output logic [LINE_W-1:0]   ret_data,
    output logic                refill_err,
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);
    refill_state_e     state_q;
    logic [31:0]       araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              ret_valid_q;
    logic              err_q;
    logic              clear;
    logic              beat_we;
    logic              burst_end;
    logic [BEAT_W-1:0] beat;

    assign clear     = (state_q == IDLE) && rd_req;
    assign beat_we   = (state_q == R) && rvalid && rready_q;
    assign burst_end = beat_we && (rlast || (beat == LAST_BEAT));

    line_assembler u_line (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .beat_we_i (beat_we),
        .rdata_i   (rdata),
        .beat_o    (beat),
        .line_o    (ret_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ret_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ret_valid_q <= 1'b0;
            if (beat_we && (rresp != RESP_OKAY)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        araddr_q  <= {rd_addr[31:4], 4'h0};
                        arvalid_q <= 1'b1;
                        state_q   <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    // An early rlast or a missing rlast on the 4th beat both end the burst as an error.
                    if (burst_end) begin
                        if (rlast != (beat == LAST_BEAT)) begin
                            err_q <= 1'b1;
                        end
                        rready_q    <= 1'b0;
                        ret_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ret_valid  = ret_valid_q;
    assign refill_err = err_q;
    assign arid       = ID_WIDTH'(AXI_ID);
    assign araddr     = araddr_q;
    assign arlen      = 8'd3;
    assign arsize     = SIZE_4B;
    assign arburst    = BURST_INCR;
    assign arlock     = 2'b00;
    assign arcache    = 4'b0000;
    assign arprot     = 3'b000;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;

    logic unused_ok;
    assign unused_ok = ^{rid, rd_addr[3:0]};
endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: drives refills, scoreboards returned lines on ret_valid.
module tb_icache_axi_refill;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_req = 1'b0;
    logic [31:0]  rd_addr = '0;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic         refill_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [1:0]   arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [3:0]   rid = '0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;

    icache_axi_refill #(.ID_WIDTH(4), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
        .ret_valid(ret_valid), .ret_data(ret_data), .refill_err(refill_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] line;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   ret_cnt = 0;
    int   req_cyc = 0;
    int   exp_lat = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] beat_word(input int i, input logic [31:0] seed);
        return (32'h1111_1111 * 32'(i + 1)) ^ seed;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (arvalid && arready) hs_cnt <= hs_cnt + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && ret_valid) begin
            ret_cnt <= ret_cnt + 1;
            chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ret_data", ret_data, e.line);
                chk("ret_err", 128'(refill_err), 128'(e.err));
                chk("ret_latency", 128'(cyc + 1 - req_cyc), 128'(exp_lat));
            end
        end
    end

    task automatic refill(input logic [31:0] addr, input int ar_stall, input int gap,
                          input int err_beat, input int last_beat, input logic [31:0] seed);
        logic [127:0] line;
        exp_t         e;
        int           h0;
        int           r0;
        line = '0;
        for (int i = 0; i <= last_beat; i++) line[32*i +: 32] = beat_word(i, seed);
        if ((err_beat >= 0 && err_beat <= last_beat) || last_beat != 3) exp_err = 1'b1;
        e.line = line;
        e.err  = exp_err;
        sb.push_back(e);
        exp_lat = 2 + ar_stall + (last_beat + 1) + gap * last_beat;
        h0 = hs_cnt;
        r0 = ret_cnt;
        rd_req  = 1'b1;
        rd_addr = addr;
        @(posedge clk); #1;
        req_cyc = cyc;
        for (int k = 0; k <= ar_stall; k++) begin
            chk("arvalid_hold", 128'(arvalid), 128'd1);
            chk("araddr_hold", 128'(araddr), 128'({addr[31:4], 4'h0}));
            if (k < ar_stall) begin
                @(posedge clk); #1;
            end
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("arvalid_drop", 128'(arvalid), 128'd0);
        chk("rready_in_r", 128'(rready), 128'd1);
        for (int i = 0; i <= last_beat; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                    chk("rready_stall", 128'(rready), 128'd1);
                end
            end
            rvalid = 1'b1;
            rdata  = beat_word(i, seed);
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = (i == last_beat);
            @(posedge clk); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
        rd_req = 1'b0;
        chk("rready_done", 128'(rready), 128'd0);
        @(posedge clk); #1;
        chk("ar_handshakes", 128'(hs_cnt - h0), 128'd1);
        chk("ret_pulses", 128'(ret_cnt - r0), 128'd1);
        chk("refill_err", 128'(refill_err), 128'(exp_err));
        chk("ret_data_hold", ret_data, line);
    endtask

    task automatic chk_reset_state();
        chk("rst_arvalid", 128'(arvalid), 128'd0);
        chk("rst_rready", 128'(rready), 128'd0);
        chk("rst_ret_valid", 128'(ret_valid), 128'd0);
        chk("rst_refill_err", 128'(refill_err), 128'd0);
        chk("rst_araddr", 128'(araddr), 128'd0);
        chk("rst_ret_data", ret_data, 128'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        #2;
        chk_reset_state();
        chk("arlen", 128'(arlen), 128'd3);
        chk("arsize", 128'(arsize), 128'd2);
        chk("arburst", 128'(arburst), 128'd1);
        chk("arid", 128'(arid), 128'd0);
        chk("ar_misc", 128'({arlock, arcache, arprot}), 128'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        refill(32'h1FC0_0014, 0, 0, -1, 3, 32'h0);
        $display("refill 1 zero-wait done, line %h", ret_data);
        chk("line_literal", ret_data, 128'h44444444_33333333_22222222_11111111);
        refill(32'h1FC0_0014, 5, 0, -1, 3, 32'h0);
        $display("refill 2 ar-stall done, line %h", ret_data);
        refill(32'h0000_2468, 0, 2, -1, 3, 32'hA5A5_0F0F);
        $display("refill 3 r-gaps done, line %h", ret_data);
        refill(32'h8000_003C, 0, 0, 1, 3, 32'h1234_5678);
        $display("refill 4 bad rresp done, err %0b", refill_err);
        refill(32'h4000_0100, 1, 1, -1, 1, 32'hDEAD_BEEF);
        $display("refill 5 early rlast done, line %h", ret_data);

        r0 = ret_cnt;
        rd_req  = 1'b1;
        rd_addr = 32'h7777_7774;
        @(posedge clk); #1;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1;
            rdata  = 32'hC0DE_0000 + 32'(i);
            @(posedge clk); #1;
            rvalid = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk_reset_state();
        rd_req  = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        chk("idle_rready", 128'(rready), 128'd0);
        chk("idle_stray_beat", ret_data, 128'd0);
        rvalid = 1'b0;
        @(posedge clk); #1;
        chk("reset_no_ret", 128'(ret_cnt - r0), 128'd0);
        $display("reset mid-burst done, err %0b", refill_err);
        refill(32'hCAFE_BABC, 0, 0, -1, 3, 32'h0F0F_0F0F);
        $display("refill 6 post-reset done, line %h", ret_data);
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
